// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF-to-ID decoupling queue of {pc, ir, pred} entries with one-cycle flush
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_ir,
  input  logic             enq_pred,
  output logic             enq_ready,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_ir,
  output logic             deq_pred,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      ir_mem   [DEPTH];
  logic [DEPTH-1:0] pred_mem;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   cnt;
  logic             enq_fire;
  logic             deq_fire;

  // Handshakes depend only on registered occupancy, never on deq_ready.
  assign enq_ready = (cnt != CNT_FULL);
  assign deq_valid = (cnt != '0);
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign deq_fire  = deq_valid & deq_ready & ~flush;
  assign count     = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[wr_ptr]   <= enq_pc;
      ir_mem[wr_ptr]   <= enq_ir;
      pred_mem[wr_ptr] <= enq_pred;
    end
  end

  assign deq_pc   = deq_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign deq_ir   = deq_valid ? ir_mem[rd_ptr]   : 32'h0;
  assign deq_pred = deq_valid ? pred_mem[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based model
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        pred;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic [31:0]      enq_pc = '0;
  logic [31:0]      enq_ir = '0;
  logic             enq_pred = 1'b0;
  logic             enq_ready;
  logic             deq_valid;
  logic             deq_ready = 1'b0;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_ir;
  logic             deq_pred;
  logic [PTR_W:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  entry_t model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_ir(enq_ir), .enq_pred(enq_pred),
    .enq_ready(enq_ready), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_ir(deq_ir), .deq_pred(deq_pred), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents follow directly from the fire rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      bit e_fire;
      bit d_fire;
      entry_t e;
      e_fire = enq_valid && (model_q.size() < DEPTH);
      d_fire = deq_ready && (model_q.size() > 0);
      if (d_fire) void'(model_q.pop_front());
      if (e_fire) begin
        e.pc = enq_pc; e.ir = enq_ir; e.pred = enq_pred;
        model_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = model_q.size();
    chk("m_count", 32'(count), 32'(sz));
    chk("m_enq_ready", 32'(enq_ready), 32'(sz != DEPTH));
    chk("m_deq_valid", 32'(deq_valid), 32'(sz != 0));
    chk("m_deq_pc", deq_pc, (sz != 0) ? model_q[0].pc : 32'h0);
    chk("m_deq_ir", deq_ir, (sz != 0) ? model_q[0].ir : 32'h0);
    chk("m_deq_pred", 32'(deq_pred), (sz != 0) ? 32'(model_q[0].pred) : 32'h0);
  end

  task automatic cyc(input logic ev, input logic [31:0] pc, input logic [31:0] ir,
                     input logic pr, input logic dr, input logic fl);
    enq_valid = ev; enq_pc = pc; enq_ir = ir; enq_pred = pr;
    deq_ready = dr; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset then idle
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_deq_ir", deq_ir, 32'h0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);

    // Basic flow
    cyc(1'b1, 32'h60, 32'h00500093, 1'b0, 1'b0, 1'b0);
    chk("basic_valid", 32'(deq_valid), 32'd1);
    chk("basic_pc", deq_pc, 32'h60);
    chk("basic_ir", deq_ir, 32'h00500093);
    chk("basic_count", 32'(count), 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("basic_drain_count", 32'(count), 32'd0);
    chk("basic_drain_valid", 32'(deq_valid), 32'd0);

    // Fill and stall
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h60 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_enq_ready", 32'(enq_ready), 32'd0);
    cyc(1'b1, 32'h70, 32'hA004, 1'b0, 1'b0, 1'b0);
    chk("fill_ignored_count", 32'(count), 32'd4);
    chk("fill_ignored_head", deq_pc, 32'h60);
    begin
      logic [31:0] exp_heads [5];
      exp_heads = '{32'h60, 32'h64, 32'h68, 32'h6C, 32'h70};
      for (int i = 0; i < 5; i++) begin
        chk("fill_head_order", deq_pc, exp_heads[i]);
        cyc(i < 2, 32'h70, 32'hA004, 1'b0, 1'b1, 1'b0);
        if (i < 2) chk("fill_count_during", 32'(count), 32'd3);
      end
    end
    chk("fill_drained", 32'(count), 32'd0);

    // Wrap-around with simultaneous traffic
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        chk("wrap_head_pc", deq_pc, 32'h100 + 32'(4 * (k - 1)));
        chk("wrap_head_pred", 32'(deq_pred), 32'(((k - 1) % 2) == 0));
      end
      cyc(1'b1, 32'h100 + 32'(4 * k), 32'hB000 + 32'(k), (k % 2) == 0, 1'b1, 1'b0);
      chk("wrap_count", 32'(count), 32'd1);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush discards everything including the same-cycle enqueue
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(4 * i), 32'hC000 + 32'(i), 1'b1, 1'b0, 1'b0);
    chk("flush_pre_count", 32'(count), 32'd3);
    cyc(1'b1, 32'h20C, 32'hC003, 1'b0, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(deq_valid), 32'd0);
    chk("flush_ir", deq_ir, 32'h0);
    chk("flush_enq_ready", 32'(enq_ready), 32'd1);
    cyc(1'b1, 32'h400, 32'hD000, 1'b0, 1'b0, 1'b0);
    chk("post_flush_valid", 32'(deq_valid), 32'd1);
    chk("post_flush_pc", deq_pc, 32'h400);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Async reset mid-stream
    cyc(1'b1, 32'h500, 32'hE000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h504, 32'hE001, 1'b0, 1'b0, 1'b0);
    enq_valid = 1'b0;
    chk("areset_pre_count", 32'(count), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_valid", 32'(deq_valid), 32'd0);
    chk("areset_pc", deq_pc, 32'h0);
    chk("areset_ir", deq_ir, 32'h0);
    chk("areset_pred", 32'(deq_pred), 32'd0);
    chk("areset_enq_ready", 32'(enq_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1'b1, 32'h600, 32'hF000, 1'b1, 1'b0, 1'b0);
    chk("areset_after_pc", deq_pc, 32'h600);
    chk("areset_after_pred", 32'(deq_pred), 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic checked by the model on every negedge
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
